// File: rtl/routex_arb_pkg.sv
// Shared types and helpers for the routex per-output arbiter.
package routex_arb_pkg;

    localparam int unsigned LEN_W     = 64;
    localparam int unsigned LEN_LSB_W = 3;
    localparam int unsigned BEATS_W   = 30;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        PLD  = 2'd2
    } state_t;

    // Payload beats for a header word-7 length: ceil(len[31:0] / 8).
    function automatic logic [BEATS_W-1:0] beats(input logic [LEN_W-1:0] len);
        return BEATS_W'(len[31:LEN_LSB_W]) + BEATS_W'(|len[LEN_LSB_W-1:0]);
    endfunction

endpackage

// File: rtl/routex_arb_if.sv
// Handshake bundle between the routex datapath and one output-port arbiter.
interface routex_arb_if
    import routex_arb_pkg::*;
#(
    parameter int unsigned NumPorts = 4
);
    localparam int unsigned IdxW = (NumPorts > 1) ? $clog2(NumPorts) : 1;

    logic [NumPorts-1:0]            req;
    logic [NumPorts-1:0][LEN_W-1:0] len;
    logic [NumPorts-1:0]            d_valid;
    logic                           q_bp;
    logic [NumPorts-1:0]            gnt;
    logic [IdxW-1:0]                gnt_idx;
    logic [NumPorts-1:0]            d_bp;
    logic                           q_sof;
    logic                           q_eof;
    logic                           busy;
    logic                           err;

    modport master (
        output req, len, d_valid, q_bp,
        input  gnt, gnt_idx, d_bp, q_sof, q_eof, busy, err
    );

    modport slave (
        input  req, len, d_valid, q_bp,
        output gnt, gnt_idx, d_bp, q_sof, q_eof, busy, err
    );

endinterface

// File: rtl/routex_rr_pick.sv
// Round-robin picker: first requester strictly after ptr, wrapping.
module routex_rr_pick #(
    parameter int unsigned NumPorts = 4,
    parameter int unsigned IdxW     = (NumPorts > 1) ? $clog2(NumPorts) : 1
) (
    input  logic [NumPorts-1:0] req,
    input  logic [IdxW-1:0]     ptr,
    output logic [NumPorts-1:0] onehot,
    output logic [IdxW-1:0]     idx
);

    logic [2*NumPorts-1:0] dbl;
    logic [NumPorts-1:0]   rot;
    logic                  found;
    int unsigned           start;
    int unsigned           k;
    int unsigned           pos;

    // Rotate the doubled request vector so ptr+1 lands at bit 0, then take the lowest set bit.
    always_comb begin
        dbl   = {req, req};
        start = (32'(ptr) + 32'd1) % NumPorts;
        rot   = NumPorts'(dbl >> start);
        found = 1'b0;
        k     = 32'd0;
        for (int i = 0; i < NumPorts; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                k     = 32'(i);
            end
        end
        pos    = (start + k) % NumPorts;
        idx    = IdxW'(pos);
        onehot = found ? (NumPorts'(1) << pos) : '0;
    end

endmodule

// File: rtl/routex_out_arb.sv
// Per-output-port packet arbiter/sequencer for the routex crossbar.
// Optional stall watchdog enabled with `define ROUTEX_ARB_WDOG_EN.
module routex_out_arb
    import routex_arb_pkg::*;
#(
    parameter int unsigned NumPorts  = 4,
    parameter int unsigned WdogLimit = 1024
) (
    input  logic          clk,
    input  logic          rst,
    routex_arb_if.slave   bus
);

    localparam int unsigned IdxW = (NumPorts > 1) ? $clog2(NumPorts) : 1;

    state_t               state;
    logic [NumPorts-1:0]  gnt_q;
    logic [IdxW-1:0]      gnt_idx_q;
    logic [IdxW-1:0]      ptr_q;
    logic [BEATS_W-1:0]   cnt_q;
    logic                 err_q;

    logic [NumPorts-1:0]  pick_gnt;
    logic [IdxW-1:0]      pick_idx;
    logic [BEATS_W-1:0]   hdr_beats_c;
    logic                 gvalid_c;
    logic                 xfer_c;
    logic                 last_c;
    logic                 wdog_hit_c;

    routex_rr_pick #(
        .NumPorts (NumPorts),
        .IdxW     (IdxW)
    ) u_pick (
        .req    (bus.req),
        .ptr    (ptr_q),
        .onehot (pick_gnt),
        .idx    (pick_idx)
    );

    // Transfer qualification and final-beat detection for the granted input.
    assign hdr_beats_c = beats(bus.len[gnt_idx_q]);
    assign gvalid_c    = |(bus.d_valid & gnt_q);
    assign xfer_c      = gvalid_c && !bus.q_bp;
    assign last_c      = ((state == HDR) && (hdr_beats_c == '0)) ||
                         ((state == PLD) && (cnt_q == BEATS_W'(1)));

`ifdef ROUTEX_ARB_WDOG_EN
    logic [15:0] wdog_q;

    assign wdog_hit_c = (state != IDLE) && !gvalid_c && !bus.q_bp &&
                        (wdog_q == 16'(WdogLimit - 1));

    // Stall counter: counts starved cycles of the granted input, frozen under downstream backpressure.
    always_ff @(posedge clk) begin
        if (rst || (state == IDLE) || xfer_c || wdog_hit_c) begin
            wdog_q <= '0;
        end else if (!gvalid_c && !bus.q_bp) begin
            wdog_q <= wdog_q + 16'd1;
        end
    end
`else
    logic unused_wdog;

    assign wdog_hit_c  = 1'b0;
    assign unused_wdog = ^32'(WdogLimit);
`endif

    // Packet FSM: arbitrate in IDLE, hold the grant through header and payload beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            gnt_q     <= '0;
            gnt_idx_q <= '0;
            ptr_q     <= IdxW'(NumPorts - 1);
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        gnt_q     <= pick_gnt;
                        gnt_idx_q <= pick_idx;
                        state     <= HDR;
                    end
                end
                HDR, PLD: begin
                    if (wdog_hit_c) begin
                        gnt_q <= '0;
                        ptr_q <= gnt_idx_q;
                        err_q <= 1'b1;
                        state <= IDLE;
                    end else if (xfer_c) begin
                        if (last_c) begin
                            gnt_q <= '0;
                            ptr_q <= gnt_idx_q;
                            state <= IDLE;
                        end else begin
                            cnt_q <= (state == HDR) ? hdr_beats_c : cnt_q - BEATS_W'(1);
                            state <= PLD;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Framing strobes and per-input backpressure; only the granted input sees downstream BP.
    assign bus.gnt     = gnt_q;
    assign bus.gnt_idx = gnt_idx_q;
    assign bus.d_bp    = rst ? '1 : (~gnt_q | {NumPorts{bus.q_bp}});
    assign bus.q_sof   = xfer_c && (state == HDR);
    assign bus.q_eof   = xfer_c && last_c;
    assign bus.busy    = (state != IDLE);
    assign bus.err     = err_q;

endmodule
